// File: rtl/qdec_pkg.sv
// qdec_pkg: shared definitions for the rotary-encoder reader.
//   - Gray state constants of the quadrature cycle (clockwise order S0->S1->S2->S3->S0)
//   - idle (pulled-up) levels of the raw encoder inputs
//   - gray_dir(): classifies a transition between two accepted {A,B} states
//   - bcd_inc()/bcd_dec(): 4-digit packed BCD counting helpers
package qdec_pkg;

    localparam logic [1:0] GRAY_S0 = 2'b00;
    localparam logic [1:0] GRAY_S1 = 2'b01;
    localparam logic [1:0] GRAY_S2 = 2'b11;
    localparam logic [1:0] GRAY_S3 = 2'b10;

    // Encoder lines and button idle high through pull-ups
    localparam logic       IDLE_A   = 1'b1;
    localparam logic       IDLE_B   = 1'b1;
    localparam logic       IDLE_BTN = 1'b1;
    localparam logic [1:0] IDLE_AB  = {IDLE_A, IDLE_B};

    typedef enum logic [1:0] {
        GDIR_NONE    = 2'd0,
        GDIR_CW      = 2'd1,
        GDIR_CCW     = 2'd2,
        GDIR_ILLEGAL = 2'd3
    } gdir_e;

    // Position of a Gray state within the clockwise cycle
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        logic [1:0] p;
        case (g)
            GRAY_S0: p = 2'd0;
            GRAY_S1: p = 2'd1;
            GRAY_S2: p = 2'd2;
            GRAY_S3: p = 2'd3;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    // Cycle distance modulo 4: +1 is clockwise, -1 counter-clockwise,
    // 2 means both bits flipped at once
    function automatic gdir_e gray_dir(input logic [1:0] prev, input logic [1:0] next);
        logic [1:0] delta;
        gdir_e      d;
        delta = gray_pos(next) - gray_pos(prev);
        case (delta)
            2'd0:    d = GDIR_NONE;
            2'd1:    d = GDIR_CW;
            2'd3:    d = GDIR_CCW;
            default: d = GDIR_ILLEGAL;
        endcase
        return d;
    endfunction

    // Packed BCD increment, 9999 wraps to 0000; carry ripples through all digits
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Packed BCD decrement, 0000 wraps to 9999; borrow ripples through all digits
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/debouncer.sv
// debouncer: 2-FF synchronizer followed by a stable-time filter.
//   clk_i   : system clock
//   rst_n_i : synchronous active-low reset
//   raw_i   : asynchronous raw input
//   state_o : accepted (debounced) level, resets to IDLE
// A new level is accepted only after the synchronized input has differed
// from the accepted level on DEB_CYCLES consecutive clock edges.
module debouncer #(
    parameter int   DEB_CYCLES = 4096,
    parameter logic IDLE       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic state_o
);

    localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

    logic        sync1_q;
    logic        sync2_q;
    logic        state_q;
    logic        state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Two-stage synchronizer for the asynchronous input
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Stable-time counter: any agreement with the accepted level restarts it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sync2_q == state_q) begin
            cnt_d = 16'd0;
        end else if (cnt_q == CNT_LAST) begin
            state_d = sync2_q;
            cnt_d   = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Accepted level and counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: rotary encoder reader producing a 16-bit position.
//   CLK        : system clock (posedge)
//   RST_N      : synchronous active-low reset
//   ENC_A/B    : raw quadrature lines (asynchronous)
//   ENC_BTN    : raw push-button, active-low (asynchronous)
//   POS        : position, nibble [3:0] = digit 1 ... [15:12] = digit 4
//   DIR        : direction of last counted detent, 1 = clockwise
//   STEP       : one-cycle pulse on a rotation-driven POS change
//   ERR        : one-cycle pulse on an illegal (two-bit) Gray transition
//   BTN_PRESS  : one-cycle pulse on an accepted button press
// Build option: define QDEC_BCD_EN to count POS in packed BCD 0000..9999;
// otherwise POS is binary modulo 2^16.
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int DEB_CYCLES   = 4096,
    parameter int DETENT_STEPS = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENC_A,
    input  logic        ENC_B,
    input  logic        ENC_BTN,
    output logic [15:0] POS,
    output logic        DIR,
    output logic        STEP,
    output logic        ERR,
    output logic        BTN_PRESS
);

    localparam logic signed [3:0] DET_POS = 4'(DETENT_STEPS);
    localparam logic signed [3:0] DET_NEG = -DET_POS;

    logic        a_acc_s;
    logic        b_acc_s;
    logic        btn_acc_s;
    logic [1:0]  ab_s;
    logic        change_s;
    logic        press_s;
    gdir_e       gdir_s;
    logic [15:0] pos_inc_s;
    logic [15:0] pos_dec_s;

    logic [1:0]        ref_q,       ref_d;
    logic              primed_q,    primed_d;
    logic signed [3:0] accum_q,     accum_d;
    logic [15:0]       pos_q,       pos_d;
    logic              dir_q,       dir_d;
    logic              step_q,      step_d;
    logic              err_q,       err_d;
    logic              btn_press_q, btn_press_d;
    logic              btn_prev_q,  btn_prev_d;

    debouncer #(.DEB_CYCLES(DEB_CYCLES), .IDLE(IDLE_A)) u_deb_a (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .raw_i   (ENC_A),
        .state_o (a_acc_s)
    );

    debouncer #(.DEB_CYCLES(DEB_CYCLES), .IDLE(IDLE_B)) u_deb_b (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .raw_i   (ENC_B),
        .state_o (b_acc_s)
    );

    debouncer #(.DEB_CYCLES(DEB_CYCLES), .IDLE(IDLE_BTN)) u_deb_btn (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .raw_i   (ENC_BTN),
        .state_o (btn_acc_s)
    );

    assign ab_s = {a_acc_s, b_acc_s};

`ifdef QDEC_BCD_EN
    assign pos_inc_s = bcd_inc(pos_q);
    assign pos_dec_s = bcd_dec(pos_q);
`else
    assign pos_inc_s = pos_q + 16'd1;
    assign pos_dec_s = pos_q - 16'd1;
`endif

    // Event detection against the reference Gray state and previous button level
    always_comb begin
        change_s = (ab_s != ref_q);
        gdir_s   = gray_dir(ref_q, ab_s);
        press_s  = btn_prev_q & ~btn_acc_s;
    end

    // Decoder, sub-step accumulator and position counter next state
    always_comb begin
        ref_d       = ref_q;
        primed_d    = primed_q;
        accum_d     = accum_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        err_d       = 1'b0;
        btn_press_d = 1'b0;
        btn_prev_d  = btn_acc_s;

        if (change_s) begin
            // Every accepted change becomes the new reference, even illegal ones
            ref_d = ab_s;
            if (!primed_q) begin
                // First accepted update after reset only loads the reference state
                primed_d = 1'b1;
            end else begin
                case (gdir_s)
                    GDIR_CW: begin
                        if (accum_q == (DET_POS - 4'sd1)) begin
                            accum_d = 4'sd0;
                            pos_d   = pos_inc_s;
                            dir_d   = 1'b1;
                            step_d  = 1'b1;
                        end else begin
                            accum_d = accum_q + 4'sd1;
                        end
                    end
                    GDIR_CCW: begin
                        if (accum_q == (DET_NEG + 4'sd1)) begin
                            accum_d = 4'sd0;
                            pos_d   = pos_dec_s;
                            dir_d   = 1'b0;
                            step_d  = 1'b1;
                        end else begin
                            accum_d = accum_q - 4'sd1;
                        end
                    end
                    GDIR_ILLEGAL: begin
                        err_d = 1'b1;
                    end
                    default: begin
                        accum_d = accum_q;
                    end
                endcase
            end
        end else begin
            ref_d = ref_q;
        end

        // A button press overrides a detent completed in the same cycle;
        // ERR is left untouched
        if (press_s) begin
            pos_d       = 16'd0;
            accum_d     = 4'sd0;
            dir_d       = dir_q;
            step_d      = 1'b0;
            btn_press_d = 1'b1;
        end else begin
            btn_press_d = 1'b0;
        end
    end

    // State and registered-output update
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ref_q       <= IDLE_AB;
            primed_q    <= 1'b0;
            accum_q     <= 4'sd0;
            pos_q       <= 16'd0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            btn_press_q <= 1'b0;
            btn_prev_q  <= IDLE_BTN;
        end else begin
            ref_q       <= ref_d;
            primed_q    <= primed_d;
            accum_q     <= accum_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            err_q       <= err_d;
            btn_press_q <= btn_press_d;
            btn_prev_q  <= btn_prev_d;
        end
    end

    assign POS       = pos_q;
    assign DIR       = dir_q;
    assign STEP      = step_q;
    assign ERR       = err_q;
    assign BTN_PRESS = btn_press_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed and random stimulus for quad_decoder with an
// event-level reference model (Gray index arithmetic, integer position).
module tb_quad_decoder;

    localparam int DEB = 8;
    localparam int DET = 4;
    localparam int WIN = DEB + 6;
    localparam int LAT = DEB + 3;
`ifdef QDEC_BCD_EN
    localparam int MODV = 10000;
`else
    localparam int MODV = 65536;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enc_a   = 1'b1;
    logic        enc_b   = 1'b1;
    logic        enc_btn = 1'b1;
    logic [15:0] pos;
    logic        dir;
    logic        step;
    logic        err;
    logic        btn_press;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         m_pos    = 0;
    int         m_acc    = 0;
    logic       m_dir    = 1'b0;
    logic       m_primed = 1'b0;
    logic [1:0] m_ab     = 2'b11;
    logic       m_btn    = 1'b1;
    int         gidx[4];
    logic [1:0] seqv[4];

    quad_decoder #(.DEB_CYCLES(DEB), .DETENT_STEPS(DET)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .ENC_A     (enc_a),
        .ENC_B     (enc_b),
        .ENC_BTN   (enc_btn),
        .POS       (pos),
        .DIR       (dir),
        .STEP      (step),
        .ERR       (err),
        .BTN_PRESS (btn_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_disp(input int v);
`ifdef QDEC_BCD_EN
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
`else
        return 16'(v);
`endif
    endfunction

    // Run one observation window, counting pulses and noting first-pulse cycle
    task automatic watch(output int ns, output int ne, output int nb,
                         output int fs, output int fe, output int fb);
        ns = 0; ne = 0; nb = 0; fs = -1; fe = -1; fb = -1;
        for (int i = 1; i <= WIN; i++) begin
            @(negedge clk);
            if (step)      begin ns++; if (fs < 0) fs = i; end
            if (err)       begin ne++; if (fe < 0) fe = i; end
            if (btn_press) begin nb++; if (fb < 0) fb = i; end
        end
    endtask

    // Drive a new raw {A,B} and button level, hold it, compare with the model
    task automatic apply(input logic [1:0] ab, input logic btn, input string tag);
        int   ns, ne, nb, fs, fe, fb;
        int   d;
        logic e_step, e_err, e_btn;
        d = 0; e_step = 1'b0; e_err = 1'b0; e_btn = 1'b0;
        enc_a   = ab[1];
        enc_b   = ab[0];
        enc_btn = btn;
        watch(ns, ne, nb, fs, fe, fb);

        if (ab != m_ab) begin
            if (!m_primed) begin
                m_primed = 1'b1;
            end else begin
                d = (gidx[ab] - gidx[m_ab] + 4) % 4;
                if (d == 1)      m_acc = m_acc + 1;
                else if (d == 3) m_acc = m_acc - 1;
                else             e_err = 1'b1;
                if (m_acc == DET) begin
                    m_acc = 0; m_pos = (m_pos + 1) % MODV; e_step = 1'b1;
                end else if (m_acc == -DET) begin
                    m_acc = 0; m_pos = (m_pos + MODV - 1) % MODV; e_step = 1'b1;
                end
            end
            m_ab = ab;
        end
        if (m_btn && !btn) begin
            e_btn = 1'b1; m_pos = 0; m_acc = 0; e_step = 1'b0;
        end
        m_btn = btn;
        if (e_step) m_dir = (d == 1);

        check({tag, ":step_cnt"}, 32'(ns), 32'(e_step));
        check({tag, ":err_cnt"},  32'(ne), 32'(e_err));
        check({tag, ":btn_cnt"},  32'(nb), 32'(e_btn));
        check({tag, ":pos"},      32'(pos), 32'(to_disp(m_pos)));
        check({tag, ":dir"},      32'(dir), 32'(m_dir));
        if (e_step) check({tag, ":step_lat"}, 32'(fs), 32'(LAT));
        if (e_err)  check({tag, ":err_lat"},  32'(fe), 32'(LAT));
        if (e_btn)  check({tag, ":btn_lat"},  32'(fb), 32'(LAT));
    endtask

    task automatic move(input int delta, input string tag);
        apply(seqv[(gidx[m_ab] + delta) % 4], m_btn, tag);
    endtask

    task automatic cw_steps(input int n);
        for (int i = 0; i < n; i++) move(1, "cw");
    endtask

    // Short pulse on ENC_A that must be filtered out
    task automatic glitch(input int len);
        int ns, ne, nb, fs, fe, fb;
        enc_a = ~enc_a;
        repeat (len) @(negedge clk);
        enc_a = ~enc_a;
        watch(ns, ne, nb, fs, fe, fb);
        check("glitch:step_cnt", 32'(ns), 32'd0);
        check("glitch:err_cnt",  32'(ne), 32'd0);
        check("glitch:pos",      32'(pos), 32'(to_disp(m_pos)));
        check("glitch:dir",      32'(dir), 32'(m_dir));
    endtask

    task automatic do_reset();
        int ns, ne, nb, fs, fe, fb;
        rst_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1; enc_btn = 1'b1;
        repeat (3) @(negedge clk);
        m_pos = 0; m_acc = 0; m_dir = 1'b0; m_primed = 1'b0; m_ab = 2'b11; m_btn = 1'b1;
        check("rst:pos",  32'(pos),       32'd0);
        check("rst:dir",  32'(dir),       32'd0);
        check("rst:step", 32'(step),      32'd0);
        check("rst:err",  32'(err),       32'd0);
        check("rst:btn",  32'(btn_press), 32'd0);
        rst_n = 1'b1;
        watch(ns, ne, nb, fs, fe, fb);
        check("post_rst:pulses", 32'(ns + ne + nb), 32'd0);
    endtask

    initial begin
        int         r;
        logic [1:0] nab;
        logic       nb;
        gidx = '{0, 1, 3, 2};
        seqv = '{2'b00, 2'b01, 2'b11, 2'b10};
        @(negedge clk);
        do_reset();

        // Prime at 01, then one clockwise detent -> POS 1, DIR 1
        apply(2'b01, 1'b1, "prime");
        apply(2'b11, 1'b1, "cw1");
        apply(2'b10, 1'b1, "cw2");
        apply(2'b00, 1'b1, "cw3");
        apply(2'b01, 1'b1, "cw4");
        check("t1:pos", 32'(pos), 32'(to_disp(1)));

        // Clear, then one counter-clockwise detent from 0 wraps
        apply(2'b01, 1'b0, "press0");
        apply(2'b01, 1'b1, "release0");
        apply(2'b00, 1'b1, "ccw1");
        apply(2'b10, 1'b1, "ccw2");
        apply(2'b11, 1'b1, "ccw3");
        apply(2'b01, 1'b1, "ccw4");
        check("t2:pos", 32'(pos), 32'(to_disp(MODV - 1)));

        glitch(5);

        // Both bits flip at once
        apply(2'b10, 1'b1, "illegal");

        // Clear, climb to 66 counts, press again
        apply(m_ab, 1'b0, "press1");
        apply(m_ab, 1'b1, "release1");
        cw_steps(66 * DET);
        check("t5:pos66", 32'(pos), 32'(to_disp(66)));
        apply(m_ab, 1'b0, "press66");
        apply(m_ab, 1'b1, "release66");

        // Press lands on the same cycle as a detent completion
        cw_steps(DET - 1);
        apply(seqv[(gidx[m_ab] + 1) % 4], 1'b0, "press_align");
        apply(m_ab, 1'b1, "release_align");

        // Reset mid-detent, then two sub-steps (first only primes)
        cw_steps(2);
        do_reset();
        move(1, "rst_sub1");
        move(1, "rst_sub2");
        check("t6:pos", 32'(pos), 32'd0);

        // Random walk including reversals, illegal jumps and button activity
        for (int k = 0; k < 150; k++) begin
            r  = int'($urandom_range(0, 9));
            nb = m_btn;
            if ($urandom_range(0, 5) == 0) nb = ~m_btn;
            if (r <= 5)      nab = seqv[(gidx[m_ab] + 1) % 4];
            else if (r <= 7) nab = seqv[(gidx[m_ab] + 3) % 4];
            else if (r == 8) nab = seqv[(gidx[m_ab] + 2) % 4];
            else             nab = m_ab;
            apply(nab, nb, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
